demux14_reg: RTL and testbench

Registered 1-to-4 stream demultiplexer with valid/ready handshaking, the clocked stage that routes a single producer stream into four consumer channels. Each accepted input word is steered to one output channel, chosen either by an explicit select or by an internal round-robin pointer. The word is held in that channel's one-entry output register until the channel's consumer takes it. A wrapping beat counter reports total accepted transfers.

---
 rtl/demux14_reg.sv | 74 +++++++
 tb/tb_demux14_reg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux14_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux14_reg
// Brief    : Registered 1-to-4 valid/ready stream demux, select or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module demux14_reg #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               mode,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [1:0]         rr_ptr,
    output logic [15:0]        beat_cnt
);

    localparam int c_NUM_CH = 4;

    logic [1:0]       r_rr_ptr;
    logic [15:0]      r_beat_cnt;
    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [c_NUM_CH];

    logic [1:0]       w_target;
    logic             w_accept;

    assign w_target = mode ? r_rr_ptr : in_sel;
    // A full target channel still accepts when its consumer drains this cycle.
    assign in_ready = !r_valid[w_target] | out_ready[w_target];
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar k = 0; k < c_NUM_CH; k++) begin : g_chan
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_accept && (w_target == 2'(k))) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end

            assign out_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 2'd0;
            r_beat_cnt <= 16'd0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
            if (mode) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign rr_ptr    = r_rr_ptr;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux14_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux14_reg
// Brief    : Directed self-checking bench for demux14_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux14_reg;

    localparam int c_WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] in_data;
    logic [1:0]         in_sel;
    logic               mode;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*c_WIDTH-1:0] out_data;
    logic [1:0]         rr_ptr;
    logic [15:0]        beat_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    demux14_reg #(.WIDTH(c_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ch(input int k);
        return out_data[k*c_WIDTH +: c_WIDTH];
    endfunction

    // Advance through one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        mode      = 1'b0;
        out_ready = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 4'b0000;
        mode = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick();
        mode = 1'b0; in_sel = 2'd2; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 4'b0101) $display("FAIL rst_pre_valid: got %b expected %b", out_valid, 4'b0101);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 2'd1 || beat_cnt !== 16'd2) $display("FAIL rst_pre_state: got rr=%0d beat=%0d expected rr=1 beat=2", rr_ptr, beat_cnt);
        else pass_cnt++;
        // Assert reset between edges; outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) $display("FAIL rst_async_out: got valid=%b data=%h expected 0/0", out_valid, out_data);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 2'd0 || beat_cnt !== 16'd0) $display("FAIL rst_async_state: got rr=%0d beat=%0d expected 0/0", rr_ptr, beat_cnt);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1; in_data = 8'h33; mode = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (beat_cnt !== 16'd0 || out_valid !== 4'b0000) $display("FAIL rst_no_accept: got beat=%0d valid=%b expected 0/0000", beat_cnt, out_valid);
        else pass_cnt++;
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_explicit();
        logic [7:0] words [4];
        logic [1:0] sels  [4];
        words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        sels  = '{2'd2, 2'd0, 2'd3, 2'd1};
        do_reset();
        mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = words[i]; in_sel = sels[i];
            tick();
            total_cnt++;
            if (out_valid !== (4'b0001 << sels[i]) || ch(int'(sels[i])) !== words[i])
                $display("FAIL explicit_word%0d: got valid=%b ch%0d=%h expected valid=%b data=%h",
                         i, out_valid, sels[i], ch(int'(sels[i])), 4'b0001 << sels[i], words[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (beat_cnt !== 16'd4 || rr_ptr !== 2'd0) $display("FAIL explicit_counts: got beat=%0d rr=%0d expected 4/0", beat_cnt, rr_ptr);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            total_cnt++;
            if (out_valid !== (4'b0001 << (i % 4)) || ch(i % 4) !== 8'h10 + 8'(i))
                $display("FAIL rr_word%0d: got valid=%b ch%0d=%h expected valid=%b data=%h",
                         i, out_valid, i % 4, ch(i % 4), 4'b0001 << (i % 4), 8'h10 + 8'(i));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (rr_ptr !== 2'd1 || beat_cnt !== 16'd5) $display("FAIL rr_counts: got rr=%0d beat=%0d expected 1/5", rr_ptr, beat_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; in_sel = 2'd1; out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_data = 8'h66;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0010 || ch(1) !== 8'h55 || in_ready !== 1'b0)
            $display("FAIL bp_hold: got valid=%b ch1=%h in_ready=%b expected 0010/55/0", out_valid, ch(1), in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ch(1) !== 8'h55 || beat_cnt !== 16'd1) $display("FAIL bp_stall: got ch1=%h beat=%0d expected 55/1", ch(1), beat_cnt);
        else pass_cnt++;
        out_ready = 4'b0010;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_comb: got %b expected 1", in_ready);
        else pass_cnt++;
        tick();
        out_ready = 4'b0000; in_valid = 1'b0;
        total_cnt++;
        if (ch(1) !== 8'h66 || out_valid !== 4'b0010 || beat_cnt !== 16'd2)
            $display("FAIL bp_refill: got ch1=%h valid=%b beat=%0d expected 66/0010/2", ch(1), out_valid, beat_cnt);
        else pass_cnt++;
    endtask

    task automatic test_rr_stall();
        do_reset();
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        mode = 1'b0; in_sel = 2'd2; out_ready = 4'b1011; in_data = 8'h77;
        tick();
        mode = 1'b1; in_data = 8'h88;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0 || rr_ptr !== 2'd2) $display("FAIL rrs_blocked: got in_ready=%b rr=%0d expected 0/2", in_ready, rr_ptr);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (rr_ptr !== 2'd2 || beat_cnt !== 16'd3 || out_valid !== 4'b0100 || ch(2) !== 8'h77)
            $display("FAIL rrs_held: got rr=%0d beat=%0d valid=%b ch2=%h expected 2/3/0100/77", rr_ptr, beat_cnt, out_valid, ch(2));
        else pass_cnt++;
        out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (ch(2) !== 8'h88 || rr_ptr !== 2'd3 || beat_cnt !== 16'd4)
            $display("FAIL rrs_release: got ch2=%h rr=%0d beat=%0d expected 88/3/4", ch(2), rr_ptr, beat_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap_mode_switch();
        do_reset();
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h5A;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (beat_cnt !== 16'hFFFF || rr_ptr !== 2'd3) $display("FAIL wrap_preload: got beat=%h rr=%0d expected ffff/3", beat_cnt, rr_ptr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (beat_cnt !== 16'd0 || rr_ptr !== 2'd0) $display("FAIL wrap_zero: got beat=%h rr=%0d expected 0/0", beat_cnt, rr_ptr);
        else pass_cnt++;
        tick(); tick(); tick();
        mode = 1'b0; in_sel = 2'd1; in_data = 8'hC3;
        tick(); tick();
        in_valid = 1'b0;
        total_cnt++;
        if (rr_ptr !== 2'd3 || beat_cnt !== 16'd5 || ch(1) !== 8'hC3 || out_valid !== 4'b0010)
            $display("FAIL mode_switch: got rr=%0d beat=%0d ch1=%h valid=%b expected 3/5/c3/0010", rr_ptr, beat_cnt, ch(1), out_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
        mode = 1'b0; out_ready = 4'b0000;
        @(negedge clk);
        test_reset();
        test_explicit();
        test_round_robin();
        test_backpressure();
        test_rr_stall();
        test_wrap_mode_switch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
